// File: rtl/ibex_fp_wb_scoreboard_if.sv
// Bundles the issue, FPU result, load writeback, hazard check and register-file
// write port of the FP writeback scoreboard.
interface ibex_fp_wb_scoreboard_if #(
  parameter int unsigned DataWidth = 16
);
  logic                 issue_valid_i;
  logic [4:0]           issue_rd_i;
  logic                 issue_ready_o;
  logic                 fpu_valid_i;
  logic [4:0]           fpu_rd_i;
  logic [DataWidth-1:0] fpu_result_i;
  logic                 fpu_ready_o;
  logic                 ld_valid_i;
  logic [4:0]           ld_rd_i;
  logic [DataWidth-1:0] ld_data_i;
  logic [4:0]           chk_rs1_i;
  logic [4:0]           chk_rs2_i;
  logic [4:0]           chk_rd_i;
  logic                 hazard_o;
  logic [4:0]           fp_waddr_a_o;
  logic [DataWidth-1:0] fp_wdata_a_o;
  logic                 fp_we_a_o;

  // Pipeline side: drives issue/results/loads/checks, observes the scoreboard
  modport master (
    output issue_valid_i, issue_rd_i, fpu_valid_i, fpu_rd_i, fpu_result_i,
           ld_valid_i, ld_rd_i, ld_data_i, chk_rs1_i, chk_rs2_i, chk_rd_i,
    input  issue_ready_o, fpu_ready_o, hazard_o, fp_waddr_a_o, fp_wdata_a_o,
           fp_we_a_o
  );

  // Scoreboard side
  modport slave (
    input  issue_valid_i, issue_rd_i, fpu_valid_i, fpu_rd_i, fpu_result_i,
           ld_valid_i, ld_rd_i, ld_data_i, chk_rs1_i, chk_rs2_i, chk_rd_i,
    output issue_ready_o, fpu_ready_o, hazard_o, fp_waddr_a_o, fp_wdata_a_o,
           fp_we_a_o
  );
endinterface

// File: rtl/ibex_fp_wb_scoreboard.sv
// FP writeback scoreboard: pending-destination bitmap, FPU result FIFO and
// load-priority arbitration onto the single FP register-file write port.
module ibex_fp_wb_scoreboard #(
  parameter bit          RV32E      = 1'b0,
  parameter int unsigned DataWidth  = 16,
  parameter int unsigned QueueDepth = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  ibex_fp_wb_scoreboard_if.slave        bus,
  output logic                          err_o
);

  localparam int unsigned PtrW    = (QueueDepth > 1) ? $clog2(QueueDepth) : 1;
  localparam int unsigned CntW    = PtrW + 1;
  localparam int unsigned NumRegs = 32;

  // With RV32E only 16 registers exist, so address bit 4 is dropped everywhere
  function automatic logic [4:0] map_addr(input logic [4:0] a);
    return RV32E ? {1'b0, a[3:0]} : a;
  endfunction

  logic [4:0] issue_idx, fpu_idx, ld_idx, rs1_idx, rs2_idx, rd_idx;

  logic [NumRegs-1:0]   pending_q, pending_d;
  logic [4:0]           fifo_rd_q   [QueueDepth];
  logic [DataWidth-1:0] fifo_data_q [QueueDepth];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 w_we_q, w_we_d;
  logic                 w_fifo_q, w_fifo_d;
  logic [4:0]           w_addr_q, w_addr_d;
  logic [DataWidth-1:0] w_data_q, w_data_d;
  logic                 err_q, err_d;

  logic full, empty, push, pop, issue_fire;

  assign issue_idx = map_addr(bus.issue_rd_i);
  assign fpu_idx   = map_addr(bus.fpu_rd_i);
  assign ld_idx    = map_addr(bus.ld_rd_i);
  assign rs1_idx   = map_addr(bus.chk_rs1_i);
  assign rs2_idx   = map_addr(bus.chk_rs2_i);
  assign rd_idx    = map_addr(bus.chk_rd_i);

  assign full       = (cnt_q == CntW'(QueueDepth));
  assign empty      = (cnt_q == '0);
  assign push       = bus.fpu_valid_i && !full;
  // Loads cannot stall, so the FIFO head only drains in load-free cycles
  assign pop        = !bus.ld_valid_i && !empty;
  assign issue_fire = bus.issue_valid_i && !pending_q[issue_idx] && (issue_idx != 5'd0);

  assign bus.issue_ready_o = !pending_q[issue_idx];
  assign bus.fpu_ready_o   = !full;
  // Register 0 is never set in the bitmap, so it always reads as not pending
  assign bus.hazard_o      = pending_q[rs1_idx] | pending_q[rs2_idx] | pending_q[rd_idx];
  assign bus.fp_we_a_o     = w_we_q;
  assign bus.fp_waddr_a_o  = w_addr_q;
  assign bus.fp_wdata_a_o  = w_data_q;
  assign err_o             = err_q;

  // Next-state: pending bitmap, FIFO pointers, write stage and error pulse
  always_comb begin
    pending_d = pending_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q + CntW'(push) - CntW'(pop);
    w_we_d    = 1'b0;
    w_fifo_d  = 1'b0;
    w_addr_d  = w_addr_q;
    w_data_d  = w_data_q;
    err_d     = 1'b0;

    // Retire the FIFO-sourced write presented this cycle; a same-edge set wins
    if (w_we_q && w_fifo_q) pending_d[w_addr_q] = 1'b0;
    if (issue_fire) pending_d[issue_idx] = 1'b1;

    if (bus.ld_valid_i) begin
      w_we_d   = 1'b1;
      w_addr_d = ld_idx;
      w_data_d = bus.ld_data_i;
    end else if (!empty) begin
      w_we_d   = 1'b1;
      w_fifo_d = 1'b1;
      w_addr_d = fifo_rd_q[rd_ptr_q];
      w_data_d = fifo_data_q[rd_ptr_q];
    end

    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);

    if (push && !pending_q[fpu_idx])          err_d = 1'b1;
    if (bus.ld_valid_i && pending_q[ld_idx])  err_d = 1'b1;
    if (bus.fpu_valid_i && full)              err_d = 1'b1;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      w_we_q    <= 1'b0;
      w_fifo_q  <= 1'b0;
      w_addr_q  <= '0;
      w_data_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      w_we_q    <= w_we_d;
      w_fifo_q  <= w_fifo_d;
      w_addr_q  <= w_addr_d;
      w_data_q  <= w_data_d;
      err_q     <= err_d;
    end
  end

  // FIFO storage; contents are qualified by the pointers, so no reset needed
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      fifo_rd_q[wr_ptr_q]   <= fpu_idx;
      fifo_data_q[wr_ptr_q] <= bus.fpu_result_i;
    end
  end

endmodule

// File: doc/ibex_fp_wb_scoreboard.md
Name: ibex_fp_wb_scoreboard

Overview:
- Write-side companion to the FP register file: the single producer of its write port (waddr/wdata/we).
- Tracks destination registers of in-flight multi-cycle FPU ops in a pending bitmap and buffers FPU results in a small FIFO.
- Arbitrates FPU results against fixed-latency FP load writebacks onto the one write port.
- Provides the RAW/WAW hazard indication the ID stage uses to stall.

Parameters:
- RV32E, 0, when 1 only 16 FP registers; address bit 4 of every address input is ignored.
- DataWidth, 16, FP register width; must match the register file.
- QueueDepth, 2, FPU result FIFO entries, power of two, >= 2.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous active-high reset.
- issue_valid_i  input  1  FPU op issuing this cycle.
- issue_rd_i  input  5  destination of issuing op.
- issue_ready_o  output  1  issue accepted (combinational).
- fpu_valid_i  input  1  FPU result valid.
- fpu_rd_i  input  5  result destination.
- fpu_result_i  input  DataWidth  result data.
- fpu_ready_o  output  1  FIFO can accept a result.
- ld_valid_i  input  1  FP load writeback; cannot be stalled.
- ld_rd_i  input  5  load destination.
- ld_data_i  input  DataWidth  load data.
- chk_rs1_i, chk_rs2_i, chk_rd_i  input  5 each  ID-stage operands to check.
- hazard_o  output  1  any checked register is pending (combinational).
- fp_waddr_a_o  output  5  to register file write address.
- fp_wdata_a_o  output  DataWidth  to register file write data.
- fp_we_a_o  output  1  to register file write enable.
- err_o  output  1  protocol error pulse.

Behaviour:
- Reset, clk_i rising edge with rst_i=1:
  - pending=0, FIFO empty.
  - fp_we_a_o=0, fp_waddr_a_o=0, fp_wdata_a_o=0, err_o=0.
  - In-flight results are dropped; results arriving after reset with rd not pending raise err_o.
- Issue:
  - issue_ready_o = !pending[issue_rd_i].
  - On the edge with issue_valid_i && issue_ready_o && issue_rd_i!=0, set pending[issue_rd_i].
  - rd=0 is never marked pending.
- Hazard: hazard_o = pending[chk_rs1_i] | pending[chk_rs2_i] | pending[chk_rd_i]; register 0 always reads 0.
- FIFO:
  - fpu_ready_o = !full.
  - Push on fpu_valid_i && fpu_ready_o.
  - Push and pop in the same cycle are both allowed; a push while full is not accepted.
  - Pointers wrap modulo QueueDepth.
- Write-stage register W, loaded every edge, with this source priority:
  1. ld_valid_i: W <= {ld_rd_i, ld_data_i, we=1}.
  2. else if FIFO non-empty: pop head, W <= {head rd, head data, we=1}.
  3. else W.we <= 0. Address and data hold their last value.
- A load always wins; the FIFO head waits. Loads never stall.
- fp_we_a_o/fp_waddr_a_o/fp_wdata_a_o come straight from W. The register file writes at the end of the cycle in which fp_we_a_o=1.
- Pending clear:
  - At the edge ending a cycle with fp_we_a_o=1 and the write sourced from the FIFO, clear pending[fp_waddr_a_o].
  - Load writes never touch pending.
  - If a set and a clear target the same index on the same edge, set wins. This case cannot legally occur, because issue_ready_o is 0 while pending.
- Timing: FPU result pushed at edge E0, FIFO was empty, no load:
  - Popped at E1; fp_we_a_o=1 during cycle E1–E2.
  - Register written and pending cleared at E2.
  - hazard_o falls in the cycle after E2. There is no bypass.
- Writes to address 0 pass to the port unchanged; the register file discards them.
- err_o is registered and 1 for one cycle after any of:
  - Accepted FPU result whose rd is not pending, or whose rd is 0.
  - ld_valid_i with pending[ld_rd_i]=1.
  - fpu_valid_i while full.
- An erroneous FPU result is still written; pending is unaffected.

Test Plan:
- Reset then idle → fp_we_a_o=0, hazard_o=0, issue_ready_o=1, fpu_ready_o=1, err_o=0.
- Issue rd=5; fpu result rd=5, data 0x3C00 two cycles later → fp_we_a_o=1, waddr=5, wdata=0x3C00 exactly 1 cycle after the push; hazard_o on chk_rs1=5 is 1 from the issue edge until the edge after the write.
- Issue rd=3 and rd=4; push both results while ld_valid_i (rd=7, 0x1234) is held for 2 cycles → load writes first, both cycles; then rd=3, then rd=4; fpu_ready_o=0 only while the FIFO is full; no results are lost.
- Issue rd=6 twice back-to-back → second issue_ready_o=0 until pending[6] clears.
- ld_valid_i rd=9 while pending[9]=1, and FPU result for rd=10 that is not pending → err_o pulses 1 cycle each; both writes still occur.
- rst_i asserted with 2 FIFO entries and pending{2,8} → next cycle pending=0, FIFO empty, fp_we_a_o=0; the late result for rd=2 raises err_o.
